tk1_exec_mon: RTL and testbench

Parametrised successor to the single-window CPU execution monitor in the tk1 core. It provides NUM_REGIONS independently configured address windows, each with its own execute/read/write permissions and a sticky lock bit. It checks every CPU bus access against those windows and drives a sticky force_trap when an access is not permitted. The block sits beside tk1 on the CPU address/valid bus and is configured by firmware through the standard cs/we/address register API.

---
 rtl/tk1_exec_mon_pkg.sv | 28 ++
 rtl/tk1_exec_mon_region.sv | 48 ++++
 rtl/tk1_exec_mon.sv | 146 ++++++++++++++
 tb/tb_tk1_exec_mon.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tk1_exec_mon_pkg.sv
// Shared definitions for the tk1 execution monitor: register map, CFG bit
// positions, trap cause codes and FSM encoding.
package tk1_exec_mon_pkg;
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_VIOL   = 8'h02;
  localparam logic [7:0] ADDR_HCNT   = 8'h03;
  localparam logic [7:0] ADDR_HIST   = 8'h04;
  localparam logic [7:0] ADDR_REGION = 8'h10;

  localparam int CFG_EN   = 0;
  localparam int CFG_X    = 1;
  localparam int CFG_R    = 2;
  localparam int CFG_W    = 3;
  localparam int CFG_LOCK = 31;

  localparam logic [1:0] CAUSE_EXEC  = 2'b01;
  localparam logic [1:0] CAUSE_READ  = 2'b10;
  localparam logic [1:0] CAUSE_WRITE = 2'b11;

  typedef enum logic {IDLE = 1'b0, TRAPPED = 1'b1} state_t;

  function automatic logic [1:0] cause_of(input logic instr, input logic we);
    if (instr)   return CAUSE_EXEC;
    else if (we) return CAUSE_WRITE;
    else         return CAUSE_READ;
  endfunction
endpackage

// File: rtl/tk1_exec_mon_region.sv
// One monitored window: FIRST/LAST/CFG registers frozen by the lock bit,
// plus combinational match and per-access-type permission outputs.
module tk1_exec_mon_region #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_first,
  input  logic                  wr_last,
  input  logic                  wr_cfg,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] first,
  output logic [ADDR_WIDTH-1:0] last,
  output logic [31:0]           cfg,
  output logic                  match,
  output logic                  allow_x,
  output logic                  allow_r,
  output logic                  allow_w
);
  import tk1_exec_mon_pkg::*;

  logic [3:0] perm;
  logic       lock;

  always_ff @(posedge clk) begin
    if (reset) begin
      first <= '0;
      last  <= '0;
      perm  <= '0;
      lock  <= 1'b0;
    end else if (!lock) begin
      if (wr_first) first <= wdata[ADDR_WIDTH-1:0];
      if (wr_last)  last  <= wdata[ADDR_WIDTH-1:0];
      // The locking write still lands its permission bits.
      if (wr_cfg) begin
        perm <= wdata[3:0];
        lock <= wdata[CFG_LOCK];
      end
    end
  end

  assign cfg     = {lock, 27'b0, perm};
  assign match   = perm[CFG_EN] && (first <= addr) && (addr <= last);
  assign allow_x = perm[CFG_X];
  assign allow_r = perm[CFG_R];
  assign allow_w = perm[CFG_W];
endmodule

// File: rtl/tk1_exec_mon.sv
// Multi-region CPU execution monitor with sticky trap and register API.
// Optional violation history enabled by defining TK1_EXEC_MON_HIST_EN.
module tk1_exec_mon #(
  parameter int NUM_REGIONS  = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter bit DEFAULT_DENY = 1'b0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  input  logic                  cpu_instr,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  force_trap,
  input  logic                  cs,
  input  logic                  we,
  input  logic [7:0]            address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  ready
);
  import tk1_exec_mon_pkg::*;

  logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] r_first, r_last;
  logic [NUM_REGIONS-1:0][31:0]           r_cfg;
  logic [NUM_REGIONS-1:0]                 r_match, r_x, r_r, r_w;

  state_t                state;
  logic                  mon_en;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [1:0]            cause;
  logic [ADDR_WIDTH-1:0] viol_addr;
  logic                  allow, viol;
  logic [31:0]           rmux;

  logic [7:0] roff;
  logic [3:0] ridx;
  logic       in_rgn;
  logic       reg_wr;

  assign roff   = address - ADDR_REGION;
  assign ridx   = roff[5:2];
  assign in_rgn = (address >= ADDR_REGION) && (roff[7:2] < 6'(NUM_REGIONS));
  assign reg_wr = cs & we;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_rgn
    logic sel;
    assign sel = reg_wr & in_rgn & (ridx == 4'(g));
    tk1_exec_mon_region #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgn (
      .clk      (clk),
      .reset    (reset),
      .wr_first (sel & (roff[1:0] == 2'd0)),
      .wr_last  (sel & (roff[1:0] == 2'd1)),
      .wr_cfg   (sel & (roff[1:0] == 2'd2)),
      .wdata    (write_data),
      .addr     (cpu_addr),
      .first    (r_first[g]),
      .last     (r_last[g]),
      .cfg      (r_cfg[g]),
      .match    (r_match[g]),
      .allow_x  (r_x[g]),
      .allow_r  (r_r[g]),
      .allow_w  (r_w[g])
    );
  end

  // Walk from the top so the lowest-index match overrides the rest.
  always_comb begin
    allow = ~DEFAULT_DENY;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (r_match[i]) allow = cpu_instr ? r_x[i] : (cpu_we ? r_w[i] : r_r[i]);
  end

  assign viol = cpu_valid & mon_en & ~allow;

`ifdef TK1_EXEC_MON_HIST_EN
  logic [3:0][ADDR_WIDTH-1:0] hist;
  logic [2:0]                 hcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      hcnt <= '0;
    end else if (viol) begin
      hist <= {hist[2:0], cpu_addr};
      if (hcnt != 3'd4) hcnt <= hcnt + 3'd1;
    end
  end
`endif

  always_comb begin
    rmux = '0;
    case (address)
      ADDR_CTRL:   rmux[0] = mon_en;
      ADDR_STATUS: rmux = {16'(cnt), 12'b0, cause, 1'b0, state == TRAPPED};
      ADDR_VIOL:   rmux = 32'(viol_addr);
`ifdef TK1_EXEC_MON_HIST_EN
      ADDR_HCNT:   rmux = 32'(hcnt);
      8'h04:       rmux = 32'(hist[0]);
      8'h05:       rmux = 32'(hist[1]);
      8'h06:       rmux = 32'(hist[2]);
      8'h07:       rmux = 32'(hist[3]);
`endif
      default: begin
        for (int i = 0; i < NUM_REGIONS; i++)
          if (in_rgn && ridx == 4'(i))
            case (roff[1:0])
              2'd0:    rmux = 32'(r_first[i]);
              2'd1:    rmux = 32'(r_last[i]);
              2'd2:    rmux = r_cfg[i];
              default: rmux = '0;
            endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mon_en     <= 1'b0;
      force_trap <= 1'b0;
      cnt        <= '0;
      cause      <= '0;
      viol_addr  <= '0;
      ready      <= 1'b0;
      read_data  <= '0;
    end else begin
      ready     <= cs;
      read_data <= (cs & ~we) ? rmux : 32'b0;
      if (reg_wr && address == ADDR_CTRL && write_data[0]) mon_en <= 1'b1;
      if (viol) begin
        if (cnt != '1) cnt <= cnt + 1'b1;
        case (state)
          IDLE: begin
            state      <= TRAPPED;
            force_trap <= 1'b1;
            viol_addr  <= cpu_addr;
            cause      <= cause_of(cpu_instr, cpu_we);
          end
          default: force_trap <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tk1_exec_mon.sv
// Bench: two monitor instances (allow-default/16-bit counter and
// deny-default/2-bit counter) driven by shared stimulus against a bench model.
module tb_tk1_exec_mon;
  logic        clk = 1'b0;
  logic        reset, cpu_valid, cpu_instr, cpu_we, cs, we;
  logic [31:0] cpu_addr, write_data;
  logic [7:0]  address;
  logic        trap0, trap1, rdy0, rdy1;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  tk1_exec_mon #(.NUM_REGIONS(4), .ADDR_WIDTH(32), .DEFAULT_DENY(1'b0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .force_trap(trap0), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(rd0), .ready(rdy0));

  tk1_exec_mon #(.NUM_REGIONS(4), .ADDR_WIDTH(32), .DEFAULT_DENY(1'b1), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .force_trap(trap1), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(rd1), .ready(rdy1));

  int checks = 0, failures = 0;

  // Model state: region config is shared, trap state is per instance.
  logic [31:0] m_first[4], m_last[4];
  logic [3:0]  m_perm[4];
  bit          m_lock[4];
  bit          m_en;
  bit          m_trap[2];
  logic [1:0]  m_cause[2];
  logic [31:0] m_vaddr[2];
  int          m_cnt[2];
  logic [31:0] m_hist[2][4];
  int          m_hcnt[2];
  int          cmax[2] = '{65535, 3};
  bit          e_ready;
  logic [31:0] e_rd[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit allowed(int k, bit ins, bit cw, logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (m_perm[i][0] && m_first[i] <= a && a <= m_last[i])
        return ins ? m_perm[i][1] : (cw ? m_perm[i][3] : m_perm[i][2]);
    return (k == 0);
  endfunction

  function automatic logic [31:0] mdl_rd(int k, logic [7:0] a);
    int i, w;
    if (a == 8'h00) return {31'b0, m_en};
    if (a == 8'h01) return {m_cnt[k][15:0], 12'b0, m_cause[k], 1'b0, m_trap[k]};
    if (a == 8'h02) return m_vaddr[k];
`ifdef TK1_EXEC_MON_HIST_EN
    if (a == 8'h03) return 32'(m_hcnt[k]);
    if (a >= 8'h04 && a <= 8'h07) return m_hist[k][a - 8'h04];
`endif
    if (a >= 8'h10 && a < 8'h20) begin
      i = (a - 8'h10) / 4;
      w = (a - 8'h10) % 4;
      if (w == 0) return m_first[i];
      if (w == 1) return m_last[i];
      if (w == 2) return {m_lock[i], 27'b0, m_perm[i]};
    end
    return 32'h0;
  endfunction

  task automatic step(input bit rst, input bit v, input bit ins, input bit cw, input logic [31:0] ca,
                      input bit rcs, input bit rwe, input logic [7:0] ra, input logic [31:0] wd);
    bit vio[2];
    int i;
    reset = rst; cpu_valid = v; cpu_instr = ins; cpu_we = cw; cpu_addr = ca;
    cs = rcs; we = rwe; address = ra; write_data = wd;
    for (int k = 0; k < 2; k++) vio[k] = v && m_en && !allowed(k, ins, cw, ca);
    if (rst) begin
      e_ready = 0; e_rd = '{0, 0}; m_en = 0;
      for (int r = 0; r < 4; r++) begin m_first[r] = 0; m_last[r] = 0; m_perm[r] = 0; m_lock[r] = 0; end
      for (int k = 0; k < 2; k++) begin
        m_trap[k] = 0; m_cause[k] = 0; m_vaddr[k] = 0; m_cnt[k] = 0; m_hcnt[k] = 0;
        m_hist[k] = '{0, 0, 0, 0};
      end
    end else begin
      e_ready = rcs;
      for (int k = 0; k < 2; k++) e_rd[k] = (rcs && !rwe) ? mdl_rd(k, ra) : 32'h0;
      for (int k = 0; k < 2; k++)
        if (vio[k]) begin
          if (m_cnt[k] < cmax[k]) m_cnt[k]++;
          if (!m_trap[k]) begin
            m_trap[k] = 1; m_vaddr[k] = ca;
            m_cause[k] = ins ? 2'b01 : (cw ? 2'b11 : 2'b10);
          end
          m_hist[k] = '{ca, m_hist[k][0], m_hist[k][1], m_hist[k][2]};
          if (m_hcnt[k] < 4) m_hcnt[k]++;
        end
      if (rcs && rwe) begin
        if (ra == 8'h00 && wd[0]) m_en = 1;
        if (ra >= 8'h10 && ra < 8'h20 && ((ra - 8'h10) % 4) != 3) begin
          i = (ra - 8'h10) / 4;
          if (!m_lock[i])
            case ((ra - 8'h10) % 4)
              0: m_first[i] = wd;
              1: m_last[i] = wd;
              default: begin m_perm[i] = wd[3:0]; m_lock[i] = wd[31]; end
            endcase
        end
      end
    end
    @(posedge clk); #1;
    check("ready0", {31'b0, rdy0}, {31'b0, e_ready});
    check("ready1", {31'b0, rdy1}, {31'b0, e_ready});
    check("rdata0", rd0, e_rd[0]);
    check("rdata1", rd1, e_rd[1]);
    check("trap0", {31'b0, trap0}, {31'b0, m_trap[0]});
    check("trap1", {31'b0, trap1}, {31'b0, m_trap[1]});
  endtask

  task automatic do_rst();                          step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d); step(0, 0, 0, 0, 0, 1, 1, a, d); endtask
  task automatic rd(input logic [7:0] a);           step(0, 0, 0, 0, 0, 1, 0, a, 0); endtask
  task automatic acc(input bit ins, input bit cw, input logic [31:0] a); step(0, 1, ins, cw, a, 0, 0, 0, 0); endtask

  initial begin
    logic [7:0]  ra;
    logic [31:0] wd;
    do_rst();
    rd(8'h01); check("lit_reset_status", rd0, 32'h0);
    check("lit_reset_trap", {31'b0, trap0}, 32'h0);

    // Exec fetch into an R/W-only window traps with cause exec.
    wr(8'h10, 32'h4000_0000); wr(8'h11, 32'h4000_0FFF); wr(8'h12, 32'hD); wr(8'h00, 1);
    acc(1, 0, 32'h4000_0010);
    check("lit_s1_trap", {31'b0, trap0}, 32'h1);
    rd(8'h01); check("lit_s1_status", rd0, 32'h0001_0005);
    rd(8'h02); check("lit_s1_viol", rd0, 32'h4000_0010);

    // Lowest region decides.
    do_rst();
    wr(8'h10, 32'h4000_0000); wr(8'h11, 32'h4000_0FFF); wr(8'h12, 32'hD);
    wr(8'h14, 32'h4000_0000); wr(8'h15, 32'h4000_0FFF); wr(8'h16, 32'h3); wr(8'h00, 1);
    acc(1, 0, 32'h4000_0010); check("lit_s2_trap", {31'b0, trap0}, 32'h1);
    do_rst();
    wr(8'h10, 32'h4000_0000); wr(8'h11, 32'h4000_0FFF); wr(8'h12, 32'h3);
    wr(8'h14, 32'h4000_0000); wr(8'h15, 32'h4000_0FFF); wr(8'h16, 32'hD); wr(8'h00, 1);
    acc(1, 0, 32'h4000_0010); check("lit_s2_notrap", {31'b0, trap0}, 32'h0);

    // Lock freezes the region until reset.
    do_rst();
    wr(8'h18, 32'h55); wr(8'h1A, 32'h8000_0005); wr(8'h18, 32'h1234); wr(8'h1A, 32'h0);
    rd(8'h18); check("lit_lock_first", rd0, 32'h55);
    rd(8'h1A); check("lit_lock_cfg", rd0, 32'h8000_0005);
    do_rst(); rd(8'h18); check("lit_lock_reset", rd0, 32'h0);

    // Default deny and counter saturation (instance 1).
    acc(0, 0, 32'h100); check("lit_dd_off", {31'b0, trap1}, 32'h0);
    wr(8'h00, 1);
    acc(0, 0, 32'h100); check("lit_dd_trap", {31'b0, trap1}, 32'h1);
    check("lit_dd_allow", {31'b0, trap0}, 32'h0);
    rd(8'h01); check("lit_dd_status", rd1, 32'h0001_0009);
    for (int n = 0; n < 4; n++) acc(n[0], 1, 32'h200 + n);
    rd(8'h01); check("lit_sat_status", rd1, 32'h0003_0009);
    rd(8'h02); check("lit_sat_viol", rd1, 32'h100);

    // Back-to-back reads and unmapped address.
    rd(8'h00); check("lit_b2b_ctrl", rd0, 32'h1);
    rd(8'h01); check("lit_b2b_status", rd0, 32'h0);
    check("lit_b2b_ready", {31'b0, rdy0}, 32'h1);
    rd(8'hFF); check("lit_unmapped", rd0, 32'h0);

    // Reset in the same cycle as a violation wins.
    step(1, 1, 0, 0, 32'h100, 0, 0, 0, 0);
    check("lit_rst_wins", {31'b0, trap1}, 32'h0);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) begin do_rst(); continue; end
      ra = 8'h00; wd = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 8'h00;
        1: ra = 8'($urandom_range(1, 7));
        2: ra = 8'($urandom);
        default: ra = 8'($urandom_range(16, 31));
      endcase
      if (ra >= 8'h10 && ra < 8'h20) begin
        if (((ra - 8'h10) % 4) == 2)
          wd = ($urandom & 32'hF) | (($urandom_range(0, 15) == 0) ? 32'h8000_0000 : 32'h0);
        else
          wd = 32'($urandom_range(0, 255));
      end
      step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           32'($urandom_range(0, 300)), $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, ra, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
